// File: rtl/eta_adder_pipe.sv
// eta_adder_pipe: two-stage valid/ready pipelined adder with an error-tolerant
// (ETA) low segment. mode=1 selects the approximate low segment, mode=0 the
// exact add. The upper segment is always added exactly in stage 2.
// Optional build macro ETA_ERR_STATS_EN adds an exact shadow datapath that
// drives err_flag and a saturating err_count; without it both are tied to 0.
module eta_adder_pipe #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err_flag,
  output logic [31:0]      err_count
);

  localparam int LW = APPROX_BITS;
  localparam int HW = WIDTH - APPROX_BITS;

  logic          s1_valid, s2_valid;
  logic [LW-1:0] s1_low;
  logic [HW-1:0] s1_a_hi, s1_b_hi;
  logic          s1_cy;

  logic          accept, deliver, s2_load;
  logic [LW-1:0] appr_low, ex_low, nxt_low;
  logic          appr_cy, ex_cy, nxt_cy;
  logic [HW:0]   upper;
  logic [WIDTH:0] sum_nxt;

  // Handshake: S1 may refill whenever it is empty or drains into S2 this cycle.
  assign out_valid = s2_valid & ~rst;
  assign in_ready  = ~rst & (~s1_valid | ~s2_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;
  assign s2_load   = s1_valid & (~s2_valid | out_ready);

  // Low segment: approximate (XOR at bit 0, OR above) or exact, selected by mode.
  always_comb begin
    appr_low    = a[LW-1:0] | b[LW-1:0];
    appr_low[0] = a[0] ^ b[0];
    appr_cy     = a[LW-1] & b[LW-1];
    {ex_cy, ex_low} = {1'b0, a[LW-1:0]} + {1'b0, b[LW-1:0]};
    nxt_low = mode ? appr_low : ex_low;
    nxt_cy  = mode ? appr_cy  : ex_cy;
  end

  // Upper segment is always exact, fed by whichever segment carry S1 captured.
  assign upper   = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{HW{1'b0}}, s1_cy};
  assign sum_nxt = {upper, s1_low};

  // Stage 1 register: low result, upper operands and segment carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_low   <= '0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_cy    <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_low   <= nxt_low;
      s1_a_hi  <= a[WIDTH-1:LW];
      s1_b_hi  <= b[WIDTH-1:LW];
      s1_cy    <= nxt_cy;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: final sum, held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      sum      <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      sum      <= sum_nxt;
    end else if (deliver) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef ETA_ERR_STATS_EN
  logic          s1_mode;
  logic [LW-1:0] s1_ex_low;
  logic          s1_ex_cy;
  logic [HW:0]   ex_upper;
  logic [WIDTH:0] exact_nxt;

  assign ex_upper  = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{HW{1'b0}}, s1_ex_cy};
  assign exact_nxt = {ex_upper, s1_ex_low};

  // Shadow exact low segment captured alongside the selected one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_mode   <= 1'b0;
      s1_ex_low <= '0;
      s1_ex_cy  <= 1'b0;
    end else if (accept) begin
      s1_mode   <= mode;
      s1_ex_low <= ex_low;
      s1_ex_cy  <= ex_cy;
    end
  end

  // Error flag travels with the sum; exact-mode beats can never flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
    end else if (s2_load) begin
      err_flag <= s1_mode & (sum_nxt != exact_nxt);
    end
  end

  // Count erroneous results as they are handed downstream, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (deliver && err_flag && (err_count != 32'hFFFF_FFFF)) begin
      err_count <= err_count + 32'd1;
    end
  end
`else
  assign err_flag  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_eta_adder_pipe.sv
// Self-checking bench for eta_adder_pipe (WIDTH=8, APPROX_BITS=4).
// Expected results are queued on accept and compared on delivery.
module tb_eta_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  sum;
  logic        err_flag;
  logic [31:0] err_count;

  typedef struct packed {
    logic [8:0] sum;
    logic       err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_cnt  = 0;
  logic [8:0]  held;

  eta_adder_pipe #(.WIDTH(8), .APPROX_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .err_flag(err_flag), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [7:0] x, logic [7:0] y, logic m);
    exp_t       r;
    logic [8:0] ex, ap;
    logic [3:0] lo;
    logic       c;
    ex    = {1'b0, x} + {1'b0, y};
    lo[0] = x[0] ^ y[0];
    for (int i = 1; i < 4; i++) lo[i] = x[i] | y[i];
    c     = x[3] & y[3];
    ap    = {({1'b0, x[7:4]} + {1'b0, y[7:4]} + {4'b0, c}), lo};
    r.sum = m ? ap : ex;
`ifdef ETA_ERR_STATS_EN
    r.err = m && (ap != ex);
`else
    r.err = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score delivery/accept at the settled pre-edge point, then
  // advance to the next falling edge.
  task automatic cycle();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("err_flag", err_flag, e.err);
        if (e.err && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
      end
    end
    if (in_valid && in_ready) sb.push_back(model(a, b, mode));
    @(posedge clk);
    @(negedge clk);
    check("err_count", err_count, exp_cnt);
  endtask

  task automatic send(logic [7:0] x, logic [7:0] y, logic m);
    a = x; b = y; mode = m; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain(int n);
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_sum", sum, 9'h000);
    check("rst_err_flag", err_flag, 1'b0);
    check("rst_err_count", err_count, 32'd0);
    rst = 1'b0;
    #1;
    check("first_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Approximate beat with two-cycle latency observed explicitly.
    send(8'h0F, 8'h01, 1'b1);
    check("lat1_out_valid", out_valid, 1'b0);
    cycle();
    check("lat2_out_valid", out_valid, 1'b1);
    check("lat2_sum", sum, 9'h00E);
    drain(2);

    send(8'h88, 8'h88, 1'b1);
    drain(3);
    send(8'hFF, 8'h01, 1'b0);
    drain(3);
`ifdef ETA_ERR_STATS_EN
    check("err_count_after_dir", err_count, 32'd2);
`else
    check("err_count_after_dir", err_count, 32'd0);
`endif

    // Back-to-back with a three-cycle consumer stall.
    send(8'h12, 8'h34, 1'b1);
    send(8'h7F, 8'h7F, 1'b1);
    out_ready = 1'b0;
    a = 8'hA5; b = 8'h5A; mode = 1'b1; in_valid = 1'b1;
    #1;
    check("full_in_ready", in_ready, 1'b0);
    held = sum;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_sum", sum, held);
      if (i < 2) check("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    cycle();
    send(8'hC8, 8'h39, 1'b0);
    drain(4);
    check("b2b_drained", sb.size(), 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom); b = 8'($urandom); mode = 1'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(4);
    check("rand_drained", sb.size(), 0);

    // Reset with two beats in flight: nothing may surface afterwards.
    send(8'h11, 8'h22, 1'b1);
    send(8'h88, 8'h88, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    sb.delete();
    exp_cnt = 0;
    cycle();
    check("postrst_out_valid", out_valid, 1'b0);
    check("postrst_sum", sum, 9'h000);
    rst = 1'b0;
    drain(4);
    check("postrst_idle_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eta_adder_pipe.md
ETA_ADDER_PIPE -- requirements
Module: eta_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 4..64.
REQ-002 Parameter APPROX_BITS, default 8, width of the inexact low segment; legal range 1..WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts operand beat this cycle.
REQ-007 a, b  input  WIDTH each  unsigned operands, sampled on accept.
REQ-008 mode  input  1  sampled on accept; 1 = approximate (ETA), 0 = exact add.
REQ-009 out_valid  output  1  result beat available.
REQ-010 out_ready  input  1  downstream accepts result beat.
REQ-011 sum  output  WIDTH+1  result, MSB is carry-out.
REQ-012 err_flag  output  1  current result differs from exact sum (see Configuration).
REQ-013 err_count  output  32  count of erroneous results delivered (see Configuration).

Function
REQ-014 Input accept = in_valid & in_ready; output deliver = out_valid & out_ready.
REQ-015 Two-stage pipeline S1, S2, each with a valid bit; latency accept-to-out_valid exactly 2 cycles when unstalled; throughput one beat per cycle.
REQ-016 S1 registers: low result segment, upper operands a[WIDTH-1:APPROX_BITS], b[WIDTH-1:APPROX_BITS], segment carry, mode.
REQ-017 Approximate low segment: bit0 = a0 XOR b0; bits 1..APPROX_BITS-1 = ai OR bi; segment carry = a[APPROX_BITS-1] AND b[APPROX_BITS-1].
REQ-018 Exact low segment: bits = (a_low + b_low) mod 2^APPROX_BITS; segment carry = true carry-out of the low add.
REQ-019 S2 computes upper segment = a_high + b_high + segment carry, width WIDTH-APPROX_BITS+1, forming sum = {upper, low}.
REQ-020 S2 loads from S1 when S1 valid and (S2 empty or out_ready); S2 holds sum stable while out_valid & !out_ready.
REQ-021 S1 loads from input when S1 empty or S1 moves to S2 in the same cycle; in_ready = !S1_valid | (!S2_valid | out_ready).
REQ-022 Simultaneous accept and deliver in the same cycle: no beat lost or duplicated; order strictly preserved.
REQ-023 Full condition: both stages valid and out_ready=0 -> in_ready=0; in_valid ignored.
REQ-024 Empty condition: out_valid=0; sum holds last value (no X).
REQ-025 in_ready is combinational from state and out_ready only; no combinational path from in_valid to out_valid.

Reset
REQ-026 rst=1 at a rising edge clears S1 and S2 valid bits, sum to 0, err_flag to 0, err_count to 0.
REQ-027 During rst=1, in_ready=0 and out_valid=0; beats in flight when rst asserts are discarded.
REQ-028 First accept possible on the first edge with rst=0.

Configuration
REQ-029 Macro ETA_ERR_STATS_EN defined: S1 also registers exact low sum and carry; S2 computes the exact sum in parallel; err_flag = (sum != exact) registered with sum; err_count increments by 1 on each delivery with err_flag=1, saturating at 0xFFFFFFFF.
REQ-030 ETA_ERR_STATS_EN undefined: no exact datapath is built; err_flag and err_count are constant 0; ports still present.
REQ-031 Exact-mode beats (mode=0) never set err_flag in either configuration.

Verification (WIDTH=8, APPROX_BITS=4, out_ready=1 unless stated)
REQ-032 a=0x0F, b=0x01, mode=1 -> sum=0x00E two cycles after accept; err_flag=1 with macro, 0 without.
REQ-033 a=0x88, b=0x88, mode=1 -> sum=0x118 (exact 0x110), err_flag=1, err_count=1 after delivery (macro on).
REQ-034 a=0xFF, b=0x01, mode=0 -> sum=0x100, err_flag=0, err_count unchanged.
REQ-035 Back-to-back 4 beats, out_ready=0 for 3 cycles after first out_valid -> in_ready=0 after 2 held beats, sum stable, all 4 results delivered in order after release.
REQ-036 rst asserted one cycle after 2 accepts -> out_valid=0, err_count=0 next cycle; no stale beat ever delivered.
